// File: rtl/tmr_vote_monitor.sv
// Majority voter for a triplicated register stage with per-replica health monitoring:
// mismatch pulses, saturating upset counters and sticky persistent-failure flags.
module tmr_vote_monitor #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8,
  parameter int PERSIST   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     inA,
  input  logic [WIDTH-1:0]     inB,
  input  logic [WIDTH-1:0]     inC,
  input  logic                 in_valid,
  input  logic                 clr,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  output logic                 errA,
  output logic                 errB,
  output logic                 errC,
  output logic                 multi_err,
  output logic [CNT_WIDTH-1:0] cntA,
  output logic [CNT_WIDTH-1:0] cntB,
  output logic [CNT_WIDTH-1:0] cntC,
  output logic                 failA,
  output logic                 failB,
  output logic                 failC
);

  localparam int RUN_W = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0]     PERSIST_C = RUN_W'(PERSIST);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  // Lane 2 = A, lane 1 = B, lane 0 = C, so {A,B,C} packs naturally.
  logic [2:0][WIDTH-1:0]     w_lane;
  logic [WIDTH-1:0]          w_vote;
  logic [2:0]                w_mis;
  logic                      w_multi;
  logic [2:0]                w_err;
  logic [2:0]                w_fail;
  logic [2:0][CNT_WIDTH-1:0] w_cnt;

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_multi;

  assign w_lane  = {inA, inB, inC};
  assign w_vote  = (inA & inB) | (inA & inC) | (inB & inC);
  assign w_multi = (w_mis[2] & w_mis[1]) | (w_mis[2] & w_mis[0]) | (w_mis[1] & w_mis[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_multi     <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      r_multi     <= in_valid & w_multi;
      if (in_valid) begin
        r_out <= w_vote;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      logic                 r_err;
      logic                 r_fail;
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [RUN_W-1:0]     r_run;
      logic [RUN_W-1:0]     w_run_inc;

      assign w_mis[gi]  = |(w_lane[gi] ^ w_vote);
      assign w_run_inc  = (r_run == PERSIST_C) ? r_run : r_run + RUN_W'(1);

      // clr only wipes statistics; the err pulse still reports the sample.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_err  <= 1'b0;
          r_fail <= 1'b0;
          r_cnt  <= '0;
          r_run  <= '0;
        end else begin
          r_err <= in_valid & w_mis[gi];
          if (clr) begin
            r_fail <= 1'b0;
            r_cnt  <= '0;
            r_run  <= '0;
          end else if (in_valid) begin
            if (w_mis[gi]) begin
              if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
              end
              r_run <= w_run_inc;
              if (w_run_inc == PERSIST_C) begin
                r_fail <= 1'b1;
              end
            end else begin
              r_run <= '0;
            end
          end
        end
      end

      assign w_err[gi]  = r_err;
      assign w_fail[gi] = r_fail;
      assign w_cnt[gi]  = r_cnt;
    end
  endgenerate

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign multi_err = r_multi;
  assign errA      = w_err[2];
  assign errB      = w_err[1];
  assign errC      = w_err[0];
  assign failA     = w_fail[2];
  assign failB     = w_fail[1];
  assign failC     = w_fail[0];
  assign cntA      = w_cnt[2];
  assign cntB      = w_cnt[1];
  assign cntC      = w_cnt[0];

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: a vector table on an 8-bit-counter instance,
// plus hand sequences for counter saturation (2-bit-counter instance) and reset.
module tb_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inA, inB, inC;
  logic       in_valid, clr;

  logic [3:0] out_0, out_1;
  logic       ov_0, ov_1, errA_0, errB_0, errC_0, errA_1, errB_1, errC_1;
  logic       multi_0, multi_1, failA_0, failB_0, failC_0, failA_1, failB_1, failC_1;
  logic [7:0] cntA_0, cntB_0, cntC_0;
  logic [1:0] cntA_1, cntB_1, cntC_1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tmr_vote_monitor #(.WIDTH(4), .CNT_WIDTH(8), .PERSIST(4)) u0 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .clr(clr),
    .out(out_0), .out_valid(ov_0), .errA(errA_0), .errB(errB_0), .errC(errC_0),
    .multi_err(multi_0), .cntA(cntA_0), .cntB(cntB_0), .cntC(cntC_0),
    .failA(failA_0), .failB(failB_0), .failC(failC_0)
  );

  tmr_vote_monitor #(.WIDTH(4), .CNT_WIDTH(2), .PERSIST(4)) u1 (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .inC(inC),
    .in_valid(in_valid), .clr(clr),
    .out(out_1), .out_valid(ov_1), .errA(errA_1), .errB(errB_1), .errC(errC_1),
    .multi_err(multi_1), .cntA(cntA_1), .cntB(cntB_1), .cntC(cntC_1),
    .failA(failA_1), .failB(failB_1), .failC(failC_1)
  );

  typedef struct {
    logic [3:0] a, b, c;
    logic       v, cl;
    logic [3:0] e_out;
    logic       e_ov;
    logic [2:0] e_err;   // {A,B,C}
    logic       e_multi;
    logic [7:0] e_ca, e_cb, e_cc;
    logic [2:0] e_fail;  // {A,B,C}
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic v, input logic cl);
    inA = a; inB = b; inC = c; in_valid = v; clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'h5, 4'h5, 4'h7, 1'b1, 1'b0, 4'h5, 1'b1, 3'b001, 1'b0, 8'd0, 8'd0, 8'd1, 3'b000};
    tbl[1]  = '{4'h5, 4'h5, 4'h5, 1'b1, 1'b0, 4'h5, 1'b1, 3'b000, 1'b0, 8'd0, 8'd0, 8'd1, 3'b000};
    tbl[2]  = '{4'h1, 4'h2, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 3'b110, 1'b1, 8'd1, 8'd1, 8'd1, 3'b000};
    tbl[3]  = '{4'hF, 4'h0, 4'hA, 1'b0, 1'b0, 4'h3, 1'b0, 3'b000, 1'b0, 8'd1, 8'd1, 8'd1, 3'b000};
    tbl[4]  = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b1, 3'b000, 1'b0, 8'd0, 8'd0, 8'd0, 3'b000};
    tbl[5]  = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd1, 8'd0, 3'b000};
    tbl[6]  = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd2, 8'd0, 3'b000};
    tbl[7]  = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd3, 8'd0, 3'b000};
    tbl[8]  = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 8'd0, 8'd3, 8'd0, 3'b000};
    tbl[9]  = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd4, 8'd0, 3'b000};
    tbl[10] = '{4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 8'd0, 8'd4, 8'd0, 3'b000};
    tbl[11] = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd5, 8'd0, 3'b000};
    tbl[12] = '{4'h0, 4'h8, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 8'd0, 8'd5, 8'd0, 3'b000};
    tbl[13] = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd6, 8'd0, 3'b000};
    tbl[14] = '{4'h0, 4'h8, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b010, 1'b0, 8'd0, 8'd7, 8'd0, 3'b010};
    tbl[15] = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 3'b000, 1'b0, 8'd0, 8'd7, 8'd0, 3'b010};
    tbl[16] = '{4'h3, 4'hC, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 8'd0, 8'd7, 8'd0, 3'b010};
    tbl[17] = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 1'b1, 3'b000, 1'b0, 8'd0, 8'd7, 8'd0, 3'b010};
    tbl[18] = '{4'h0, 4'h5, 4'hA, 1'b0, 1'b0, 4'hF, 1'b0, 3'b000, 1'b0, 8'd0, 8'd7, 8'd0, 3'b010};
    tbl[19] = '{4'hE, 4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 3'b100, 1'b0, 8'd0, 8'd0, 8'd0, 3'b000};
    tbl[20] = '{4'h1, 4'h2, 4'h4, 1'b1, 1'b0, 4'h0, 1'b1, 3'b111, 1'b1, 8'd1, 8'd1, 8'd1, 3'b000};

    // Reset with live, valid inputs: everything must stay cleared.
    rst = 1'b1; inA = 4'h1; inB = 4'h1; inC = 4'h1; in_valid = 1'b1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_0), 32'h0);
    chk("rst_ov", 32'(ov_0), 32'h0);
    chk("rst_cnt", 32'({cntA_0, cntB_0, cntC_0}), 32'h0);
    chk("rst_fail", 32'({failA_0, failB_0, failC_0}), 32'h0);
    chk("rst_err", 32'({errA_0, errB_0, errC_0, multi_0}), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_out", 32'(out_0), 32'h1);
    chk("post_rst_ov", 32'(ov_0), 32'h1);
    chk("post_rst_err", 32'({errA_0, errB_0, errC_0}), 32'h0);
    $display("reset: out=%h out_valid=%b", out_0, ov_0);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].cl);
      $display("vec %0d: in=%h/%h/%h v=%b clr=%b -> out=%h ov=%b err=%b%b%b multi=%b cnt=%0d/%0d/%0d fail=%b%b%b",
               i, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].v, tbl[i].cl, out_0, ov_0,
               errA_0, errB_0, errC_0, multi_0, cntA_0, cntB_0, cntC_0, failA_0, failB_0, failC_0);
      chk($sformatf("v%0d_out", i), 32'(out_0), 32'(tbl[i].e_out));
      chk($sformatf("v%0d_ov", i), 32'(ov_0), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d_err", i), 32'({errA_0, errB_0, errC_0}), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_multi", i), 32'(multi_0), 32'(tbl[i].e_multi));
      chk($sformatf("v%0d_cntA", i), 32'(cntA_0), 32'(tbl[i].e_ca));
      chk($sformatf("v%0d_cntB", i), 32'(cntB_0), 32'(tbl[i].e_cb));
      chk($sformatf("v%0d_cntC", i), 32'(cntC_0), 32'(tbl[i].e_cc));
      chk($sformatf("v%0d_fail", i), 32'({failA_0, failB_0, failC_0}), 32'(tbl[i].e_fail));
    end

    // Saturation on the 2-bit counter instance.
    drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("sat_clr_cntA", 32'(cntA_1), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
      $display("sat %0d: errA=%b cntA=%0d failA=%b (wide cntA=%0d)", k, errA_1, cntA_1, failA_1, cntA_0);
      chk($sformatf("sat%0d_errA", k), 32'(errA_1), 32'h1);
      chk($sformatf("sat%0d_cntA", k), 32'(cntA_1), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("sat%0d_failA", k), 32'(failA_1), (k >= 4) ? 32'd1 : 32'd0);
      chk($sformatf("sat%0d_wide_cntA", k), 32'(cntA_0), 32'(k));
    end
    drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b1);
    $display("sat clr: errA=%b cntA=%0d failA=%b", errA_1, cntA_1, failA_1);
    chk("satclr_errA", 32'(errA_1), 32'h1);
    chk("satclr_cntA", 32'(cntA_1), 32'h0);
    chk("satclr_failA", 32'(failA_1), 32'h0);

    // Mid-operation reset: asynchronous clear, then overrides clr and in_valid.
    drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
    drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("pre_rst_cntA", 32'(cntA_0), 32'h2);
    rst = 1'b1;
    #2;
    chk("async_rst_cntA", 32'(cntA_0), 32'h0);
    chk("async_rst_ov", 32'(ov_0), 32'h0);
    drive(4'h1, 4'h0, 4'h0, 1'b1, 1'b1);
    chk("held_rst_state", 32'({ov_0, errA_0, cntA_0}), 32'h0);
    rst = 1'b0;
    drive(4'h5, 4'h5, 4'h7, 1'b1, 1'b0);
    $display("after rst: out=%h errC=%b cntC=%0d cntA=%0d", out_0, errC_0, cntC_0, cntA_0);
    chk("rel_out", 32'(out_0), 32'h5);
    chk("rel_errC", 32'(errC_0), 32'h1);
    chk("rel_cntC", 32'(cntC_0), 32'h1);
    chk("rel_cntA", 32'(cntA_0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
